router_pkt_tx: RTL

- Packet transmitter that drives the router's 3-bit input port: pkt_valid, data_in, busy.
- A host first loads payload words into an internal buffer, then pulses start.
- The block then emits header, payload words and a trailing parity word, stalling on busy.
- Used as the upstream source in router system benches and as the on-chip packet injector.

---
 rtl/router_pkt_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding a router input port (pkt_valid / data_in / busy).
// A host fills the payload buffer while idle, then pulses start. The block
// emits a header word {tag, dest_addr}, the buffered payload words and a
// trailing parity word (XOR of header and payload), holding each word while
// the router asserts busy. All outputs are registered.
module router_pkt_tx #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       wr_data,
  input  logic             start,
  input  logic [1:0]       dest_addr,
  input  logic             tag,
  input  logic             inj_err,
  input  logic             busy,
  output logic [2:0]       data_out,
  output logic             pkt_valid,
  output logic             tx_active,
  output logic             pkt_done,
  output logic             start_err,
  output logic             wr_drop,
  output logic [CNT_W-1:0] buf_count
);

  // Buffer pointer width; storage is rounded up to a power of two so that a
  // pointer slice of the count can index it without range issues.
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload,
    StParity
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       data_out_q, data_out_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             tx_active_q, tx_active_d;
  logic             pkt_done_q, pkt_done_d;
  logic             start_err_q, start_err_d;
  logic             wr_drop_q, wr_drop_d;
  logic [CNT_W-1:0] buf_count_q, buf_count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [2:0]       parity_q, parity_d;
  logic             inj_q, inj_d;

  logic [2:0]       buf_q [DEPTH];
  logic             buf_we;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] nx_ptr;
  logic [CNT_W-1:0] nx_idx;
  logic [CNT_W-1:0] eff_count;
  logic [2:0]       acc;

  assign wr_ptr = buf_count_q[IDX_W-1:0];
  assign rd_ptr = idx_q[IDX_W-1:0];
  assign nx_idx = idx_q + ONE_CNT;
  assign nx_ptr = nx_idx[IDX_W-1:0];

  // Next-state and registered-output logic for the transmit FSM.
  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    tx_active_d = tx_active_q;
    pkt_done_d  = 1'b0;
    start_err_d = 1'b0;
    wr_drop_d   = 1'b0;
    buf_count_d = buf_count_q;
    idx_d       = idx_q;
    parity_d    = parity_q;
    inj_d       = inj_q;
    buf_we      = 1'b0;
    eff_count   = buf_count_q;
    acc         = parity_q ^ buf_q[rd_ptr];

    case (state_q)
      StIdle: begin
        data_out_d  = 3'd0;
        pkt_valid_d = 1'b0;
        tx_active_d = 1'b0;
        // A same-cycle write lands first and counts toward the start check.
        if (wr_en) begin
          if (buf_count_q < MAX_CNT) begin
            buf_we    = 1'b1;
            eff_count = buf_count_q + ONE_CNT;
          end else begin
            wr_drop_d = 1'b1;
          end
        end
        buf_count_d = eff_count;
        if (start) begin
          if (eff_count == '0 || dest_addr == 2'd3) begin
            start_err_d = 1'b1;
          end else begin
            state_d     = StHeader;
            data_out_d  = {tag, dest_addr};
            pkt_valid_d = 1'b1;
            tx_active_d = 1'b1;
            parity_d    = {tag, dest_addr};
            inj_d       = inj_err;
            idx_d       = '0;
          end
        end
      end
      StHeader: begin
        if (!busy) begin
          state_d    = StPayload;
          data_out_d = buf_q[0];
        end
      end
      StPayload: begin
        // Accumulate only on acceptance so stalls never fold a word twice.
        if (!busy) begin
          parity_d = acc;
          if (idx_q == buf_count_q - ONE_CNT) begin
            state_d     = StParity;
            data_out_d  = inj_q ? ~acc : acc;
            pkt_valid_d = 1'b0;
          end else begin
            idx_d      = nx_idx;
            data_out_d = buf_q[nx_ptr];
          end
        end
      end
      StParity: begin
        if (!busy) begin
          state_d     = StIdle;
          pkt_done_d  = 1'b1;
          data_out_d  = 3'd0;
          tx_active_d = 1'b0;
          buf_count_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      data_out_q  <= 3'd0;
      pkt_valid_q <= 1'b0;
      tx_active_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      start_err_q <= 1'b0;
      wr_drop_q   <= 1'b0;
      buf_count_q <= '0;
      idx_q       <= '0;
      parity_q    <= 3'd0;
      inj_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      tx_active_q <= tx_active_d;
      pkt_done_q  <= pkt_done_d;
      start_err_q <= start_err_d;
      wr_drop_q   <= wr_drop_d;
      buf_count_q <= buf_count_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      inj_q       <= inj_d;
    end
  end

  // Payload storage; contents are only meaningful below buf_count.
  always_ff @(posedge clock) begin
    if (buf_we) begin
      buf_q[wr_ptr] <= wr_data;
    end
  end

  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign tx_active = tx_active_q;
  assign pkt_done  = pkt_done_q;
  assign start_err = start_err_q;
  assign wr_drop   = wr_drop_q;
  assign buf_count = buf_count_q;

endmodule
